// File: rtl/register_file_if.sv
// Commit, rename and operand-lookup signals between the ROB/decoder and the register file.
interface register_file_if #(
   parameter int ROB_ID_W = 4
);
   logic                rdy;
   logic                clear;
   logic                need_set_reg_value;
   logic [4:0]          set_reg_id;
   logic [31:0]         set_reg_val;
   logic [ROB_ID_W-1:0] set_reg_rob_id;
   logic                need_set_reg_dep;
   logic [4:0]          set_dep_reg;
   logic [ROB_ID_W-1:0] set_dep_rob_id;
   logic [4:0]          rs1;
   logic [4:0]          rs2;
   logic [ROB_ID_W-1:0] need_rob_id1;
   logic [ROB_ID_W-1:0] need_rob_id2;
   logic                rob_value1_ready;
   logic                rob_value2_ready;
   logic [31:0]         rob_value1;
   logic [31:0]         rob_value2;
   logic [31:0]         val1;
   logic [31:0]         val2;
   logic                has_dep1;
   logic                has_dep2;
   logic [ROB_ID_W-1:0] dep1;
   logic [ROB_ID_W-1:0] dep2;

   modport slave (
      input  rdy, clear,
      input  need_set_reg_value, set_reg_id,
      input  set_reg_val, set_reg_rob_id,
      input  need_set_reg_dep, set_dep_reg,
      input  set_dep_rob_id,
      input  rs1, rs2,
      input  rob_value1_ready, rob_value2_ready,
      input  rob_value1, rob_value2,
      output need_rob_id1, need_rob_id2,
      output val1, val2,
      output has_dep1, has_dep2,
      output dep1, dep2
   );

   modport master (
      output rdy, clear,
      output need_set_reg_value, set_reg_id,
      output set_reg_val, set_reg_rob_id,
      output need_set_reg_dep, set_dep_reg,
      output set_dep_rob_id,
      output rs1, rs2,
      output rob_value1_ready, rob_value2_ready,
      output rob_value1, rob_value2,
      input  need_rob_id1, need_rob_id2,
      input  val1, val2,
      input  has_dep1, has_dep2,
      input  dep1, dep2
   );
endinterface

// File: rtl/register_file.sv
// Architectural registers x0..x31 with busy/ROB-id status table.
// Resolves decoder operands to a value or a ROB dependency in the same cycle.
module register_file #(
   parameter int ROB_ID_W = 4
) (
   input logic            clk,
   input logic            rst,
   register_file_if.slave bus
);

   logic [31:0]         regs [32];
   logic [31:0]         busy;
   logic [ROB_ID_W-1:0] dep  [32];

   logic                commit_ok;
   logic                rename_ok;

   assign commit_ok = bus.need_set_reg_value
                      && (bus.set_reg_id != 5'd0);
   assign rename_ok = bus.need_set_reg_dep
                      && (bus.set_dep_reg != 5'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
            dep[i]  <= '0;
         end
      end else if (bus.rdy) begin
         if (bus.clear) begin
            busy <= '0;
            for (int i = 0; i < 32; i++) begin
               dep[i] <= '0;
            end
         end else begin
            if (commit_ok) begin
               regs[bus.set_reg_id] <= bus.set_reg_val;
               if (busy[bus.set_reg_id]
                   && dep[bus.set_reg_id] == bus.set_reg_rob_id)
                  busy[bus.set_reg_id] <= 1'b0;
            end
            // Later assignment lets a same-cycle rename win.
            if (rename_ok) begin
               busy[bus.set_dep_reg] <= 1'b1;
               dep[bus.set_dep_reg]  <= bus.set_dep_rob_id;
            end
         end
      end
   end

   logic [4:0]          rs     [2];
   logic                rv_rdy [2];
   logic [31:0]         rv     [2];
   logic [31:0]         lk_val [2];
   logic                lk_hd  [2];
   logic [ROB_ID_W-1:0] lk_dep [2];
   logic [ROB_ID_W-1:0] lk_nid [2];

   assign rs[0]     = bus.rs1;
   assign rs[1]     = bus.rs2;
   assign rv_rdy[0] = bus.rob_value1_ready;
   assign rv_rdy[1] = bus.rob_value2_ready;
   assign rv[0]     = bus.rob_value1;
   assign rv[1]     = bus.rob_value2;

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         lk_val[k] = '0;
         lk_hd[k]  = 1'b0;
         lk_dep[k] = '0;
         lk_nid[k] = dep[rs[k]];
         if (rs[k] != 5'd0) begin
            if (!busy[rs[k]]) begin
               lk_val[k] = regs[rs[k]];
            end else if (bus.need_set_reg_value
                         && bus.set_reg_id == rs[k]
                         && bus.set_reg_rob_id == dep[rs[k]]) begin
               lk_val[k] = bus.set_reg_val;
            end else if (rv_rdy[k]) begin
               lk_val[k] = rv[k];
            end else begin
               lk_hd[k]  = 1'b1;
               lk_dep[k] = dep[rs[k]];
            end
         end
      end
   end

   assign bus.val1         = lk_val[0];
   assign bus.val2         = lk_val[1];
   assign bus.has_dep1     = lk_hd[0];
   assign bus.has_dep2     = lk_hd[1];
   assign bus.dep1         = lk_dep[0];
   assign bus.dep2         = lk_dep[1];
   assign bus.need_rob_id1 = lk_nid[0];
   assign bus.need_rob_id2 = lk_nid[1];

endmodule

// File: tb/tb_register_file.sv
// Directed vector table plus randomized run against an array-based model.
module tb_register_file;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   register_file_if #(.ROB_ID_W(4)) bus ();

   register_file #(.ROB_ID_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rdy, clr, cs;
      logic [4:0]  cid;
      logic [31:0] cval;
      logic [3:0]  crob;
      logic        rn;
      logic [4:0]  rreg;
      logic [3:0]  rrob;
      logic [4:0]  r1, r2;
      logic        y1;
      logic [31:0] v1;
      logic        y2;
      logic [31:0] v2;
      logic [31:0] ev1;
      logic        eh1;
      logic [3:0]  ed1;
      logic [31:0] ev2;
      logic        eh2;
      logic [3:0]  ed2;
   } vec_t;

   vec_t tbl [22];

   logic [31:0] m_regs [32];
   bit          m_busy [32];
   logic [3:0]  m_dep  [32];

   function automatic vec_t mk(
      input int rdy, clr, cs, cid,
      input logic [31:0] cval, input int crob,
      input int rn, rreg, rrob, r1, r2,
      input int y1, input logic [31:0] v1,
      input int y2, input logic [31:0] v2,
      input logic [31:0] ev1, input int eh1, ed1,
      input logic [31:0] ev2, input int eh2, ed2);
      vec_t v;
      v.rdy  = 1'(rdy);  v.clr = 1'(clr);
      v.cs   = 1'(cs);   v.cid = 5'(cid);
      v.cval = cval;     v.crob = 4'(crob);
      v.rn   = 1'(rn);   v.rreg = 5'(rreg);
      v.rrob = 4'(rrob);
      v.r1   = 5'(r1);   v.r2 = 5'(r2);
      v.y1   = 1'(y1);   v.v1 = v1;
      v.y2   = 1'(y2);   v.v2 = v2;
      v.ev1  = ev1;      v.eh1 = 1'(eh1);
      v.ed1  = 4'(ed1);
      v.ev2  = ev2;      v.eh2 = 1'(eh2);
      v.ed2  = 4'(ed2);
      return v;
   endfunction

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %h expected %h",
                  nm, $time, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.rdy                = v.rdy;
      bus.clear              = v.clr;
      bus.need_set_reg_value = v.cs;
      bus.set_reg_id         = v.cid;
      bus.set_reg_val        = v.cval;
      bus.set_reg_rob_id     = v.crob;
      bus.need_set_reg_dep   = v.rn;
      bus.set_dep_reg        = v.rreg;
      bus.set_dep_rob_id     = v.rrob;
      bus.rs1                = v.r1;
      bus.rs2                = v.r2;
      bus.rob_value1_ready   = v.y1;
      bus.rob_value1         = v.v1;
      bus.rob_value2_ready   = v.y2;
      bus.rob_value2         = v.v2;
   endtask

   task automatic m_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
         m_dep[i]  = '0;
      end
   endtask

   // Model of the operand rules, evaluated on the state before the edge.
   task automatic m_look(input vec_t v, input int k,
                         output logic [31:0] ev,
                         output logic eh,
                         output logic [3:0] en);
      logic [4:0]  r;
      logic        y;
      logic [31:0] rv;
      r  = (k == 0) ? v.r1 : v.r2;
      y  = (k == 0) ? v.y1 : v.y2;
      rv = (k == 0) ? v.v1 : v.v2;
      en = m_dep[r];
      ev = 0;
      eh = 0;
      if (r == 0) ev = 0;
      else if (!m_busy[r]) ev = m_regs[r];
      else if (v.cs && v.cid == r && v.crob == m_dep[r]) ev = v.cval;
      else if (y) ev = rv;
      else eh = 1;
   endtask

   task automatic m_step(input vec_t v);
      if (!v.rdy) return;
      if (v.clr) begin
         for (int i = 0; i < 32; i++) begin
            m_busy[i] = 1'b0;
            m_dep[i]  = '0;
         end
         return;
      end
      if (v.cs && v.cid != 0) begin
         m_regs[v.cid] = v.cval;
         if (m_busy[v.cid] && m_dep[v.cid] == v.crob)
            m_busy[v.cid] = 1'b0;
      end
      if (v.rn && v.rreg != 0) begin
         m_busy[v.rreg] = 1'b1;
         m_dep[v.rreg]  = v.rrob;
      end
   endtask

   task automatic check_out(input string tag,
                            input logic [31:0] ev1,
                            input logic eh1,
                            input logic [3:0] ed1,
                            input logic [31:0] ev2,
                            input logic eh2,
                            input logic [3:0] ed2);
      chk({tag, ".val1"}, bus.val1, ev1);
      chk({tag, ".has_dep1"}, 32'(bus.has_dep1), 32'(eh1));
      chk({tag, ".need_rob_id1"}, 32'(bus.need_rob_id1), 32'(ed1));
      if (eh1) chk({tag, ".dep1"}, 32'(bus.dep1), 32'(ed1));
      chk({tag, ".val2"}, bus.val2, ev2);
      chk({tag, ".has_dep2"}, 32'(bus.has_dep2), 32'(eh2));
      chk({tag, ".need_rob_id2"}, 32'(bus.need_rob_id2), 32'(ed2));
      if (eh2) chk({tag, ".dep2"}, 32'(bus.dep2), 32'(ed2));
   endtask

   initial begin
      vec_t        v;
      logic [31:0] ev1, ev2;
      logic        eh1, eh2;
      logic [3:0]  en1, en2;

      checks = 0;
      errors = 0;
      rst    = 1'b1;
      drive(mk(1,0, 0,0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0, 0,0,0));
      m_reset();

      tbl[0]  = mk(1,0, 0,0,0,0,           0,0,0, 5,7, 0,0,0,0,      0,0,0,        0,0,0);
      tbl[1]  = mk(1,0, 0,0,0,0,           1,5,3, 5,0, 0,0,0,0,      0,0,0,        0,0,0);
      tbl[2]  = mk(1,0, 0,0,0,0,           0,0,0, 5,0, 0,0,0,0,      0,1,3,        0,0,0);
      tbl[3]  = mk(1,0, 0,0,0,0,           0,0,0, 5,0, 1,32'h1234,0,0, 32'h1234,0,3, 0,0,0);
      tbl[4]  = mk(1,0, 1,5,32'hAA,3,      0,0,0, 0,5, 0,0,0,0,      0,0,0,        32'hAA,0,3);
      tbl[5]  = mk(1,0, 0,0,0,0,           0,0,0, 0,5, 0,0,0,0,      0,0,0,        32'hAA,0,3);
      tbl[6]  = mk(1,0, 0,0,0,0,           1,7,2, 7,0, 0,0,0,0,      0,0,0,        0,0,0);
      tbl[7]  = mk(1,0, 0,0,0,0,           1,7,6, 7,0, 0,0,0,0,      0,1,2,        0,0,0);
      tbl[8]  = mk(1,0, 1,7,32'h55,2,      0,0,0, 7,0, 0,0,0,0,      0,1,6,        0,0,0);
      tbl[9]  = mk(1,0, 1,7,32'h66,6,      1,7,9, 7,7, 0,0,0,0,      32'h66,0,6,   32'h66,0,6);
      tbl[10] = mk(1,0, 0,0,0,0,           0,0,0, 7,7, 0,0,1,32'h77, 0,1,9,        32'h77,0,9);
      tbl[11] = mk(1,0, 1,1,32'h11,0,      0,0,0, 1,0, 0,0,0,0,      0,0,0,        0,0,0);
      tbl[12] = mk(1,0, 0,0,0,0,           1,1,1, 1,0, 0,0,0,0,      32'h11,0,0,   0,0,0);
      tbl[13] = mk(1,0, 0,0,0,0,           1,2,2, 1,2, 0,0,0,0,      0,1,1,        0,0,0);
      tbl[14] = mk(1,0, 0,0,0,0,           1,3,3, 2,0, 0,0,0,0,      0,1,2,        0,0,0);
      tbl[15] = mk(1,0, 0,0,0,0,           1,4,4, 4,3, 0,0,0,0,      0,0,0,        0,1,3);
      tbl[16] = mk(1,1, 1,1,32'hBAD,1,     0,0,0, 1,2, 0,0,0,0,      32'hBAD,0,1,  0,1,2);
      tbl[17] = mk(1,0, 0,0,0,0,           0,0,0, 1,4, 0,0,0,0,      32'h11,0,0,   0,0,0);
      tbl[18] = mk(0,0, 1,1,32'h99,0,      1,3,5, 1,3, 0,0,0,0,      32'h11,0,0,   0,0,0);
      tbl[19] = mk(1,0, 0,0,0,0,           0,0,0, 1,3, 0,0,0,0,      32'h11,0,0,   0,0,0);
      tbl[20] = mk(1,0, 1,0,32'hFFFFFFFF,5, 1,0,5, 0,0, 0,0,0,0,     0,0,0,        0,0,0);
      tbl[21] = mk(1,0, 0,0,0,0,           1,5,12, 0,7, 0,0,0,0,     0,0,0,        32'h66,0,0);

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 22; i++) begin
         drive(tbl[i]);
         #2;
         check_out($sformatf("vec%0d", i),
                   tbl[i].ev1, tbl[i].eh1, tbl[i].ed1,
                   tbl[i].ev2, tbl[i].eh2, tbl[i].ed2);
         m_step(tbl[i]);
         @(posedge clk);
         #1;
      end

      // Asynchronous reset between edges wipes values and status at once.
      drive(mk(1,0, 0,0,0,0, 0,0,0, 5,7, 0,0,0,0, 0,0,0, 0,0,0));
      #2 rst = 1'b1;
      #1 check_out("async_rst", 0, 0, 0, 0, 0, 0);
      #1 rst = 1'b0;
      m_reset();
      @(posedge clk);
      #1;

      for (int n = 0; n < 600; n++) begin
         v = mk(($urandom % 8) != 0, ($urandom % 25) == 0,
                $urandom % 2, $urandom % 8, $urandom,
                $urandom % 16,
                $urandom % 2, $urandom % 8, $urandom % 16,
                $urandom % 8, $urandom % 8,
                ($urandom % 3) == 0, $urandom,
                ($urandom % 3) == 0, $urandom,
                0, 0, 0, 0, 0, 0);
         drive(v);
         #2;
         m_look(v, 0, ev1, eh1, en1);
         m_look(v, 1, ev2, eh2, en2);
         check_out($sformatf("rnd%0d", n),
                   ev1, eh1, en1, ev2, eh2, en2);
         m_step(v);
         @(posedge clk);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
